seg_scan_capture: RTL

- Receive-side counterpart of the BCD-to-seven-segment decoder and 4-digit multiplexed display driver.
- Observes a multiplexed display bus (segment + anode), waits for each digit pattern to settle, and maps it back to a BCD value.
- Assembles complete 4-digit frames and flags illegal codes, illegal anode states and stalled scanning.
- Used as a loop-back checker in the banner/display designs and as a capture front-end for external displays.

---
 rtl/seg_defs.sv | 26 ++
 rtl/seg_pattern_lookup.sv | 32 +++
 rtl/seg_scan_capture.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_defs.sv
// Shared definitions for the seven-segment capture path: legal segment codes,
// capture FSM encoding and digit count.
package seg_defs;

   localparam int NUM_DIGITS = 4;

   // gfedcba, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h67;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_STALL   = 2'd2
   } state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Inverse of the BCD-to-seven-segment decoder: maps an observed segment
// pattern back to its BCD value, flagging blank and unknown patterns.
module seg_pattern_lookup
   import seg_defs::*;
(
   input  logic [6:0] segment,
   output logic [3:0] value,
   output logic       legal,
   output logic       is_blank
);

   always_comb begin
      value    = 4'd0;
      legal    = 1'b1;
      is_blank = 1'b0;
      case (segment)
         SEG_0:     value = 4'd0;
         SEG_1:     value = 4'd1;
         SEG_2:     value = 4'd2;
         SEG_3:     value = 4'd3;
         SEG_4:     value = 4'd4;
         SEG_5:     value = 4'd5;
         SEG_6:     value = 4'd6;
         SEG_7:     value = 4'd7;
         SEG_8:     value = 4'd8;
         SEG_9:     value = 4'd9;
         SEG_BLANK: is_blank = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 4-digit seven-segment bus back into BCD frames,
// flagging illegal patterns, multi-hot anodes and lost scan activity.
//
// state   | meaning
// IDLE    | out of reset, no legal digit accepted yet
// COLLECT | assembling frames; timeout running since last one-hot accept
// STALL   | no one-hot accept for TIMEOUT_CYCLES; stalled=1 until next legal digit
module seg_scan_capture
   import seg_defs::*;
#(
   parameter int STABLE_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES   = 65536,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [6:0]              segment,
   input  logic [NUM_DIGITS-1:0]   anode,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    frame_valid,
   output logic                    error,
   output logic                    stalled
);

   localparam int WORD_W = 7 + NUM_DIGITS;
   localparam int SCW    = $clog2(STABLE_CYCLES + 1);
   localparam int TCW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [SCW-1:0]        STABLE_MAX  = SCW'(STABLE_CYCLES);
   localparam logic [SCW-1:0]        STABLE_LAST = SCW'(STABLE_CYCLES - 1);
   localparam logic [TCW-1:0]        TMO_MAX     = TCW'(TIMEOUT_CYCLES);
   localparam logic [TCW-1:0]        TMO_LAST    = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_IDLE  = ANODE_ACTIVE_LOW ? '1 : '0;
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN    = '1;

   logic [WORD_W-1:0]     sync1, sync2, sync_prev;
   logic [SCW-1:0]        stab_cnt;
   logic [TCW-1:0]        tmo_cnt;
   logic [NUM_DIGITS-1:0] en, seen, seen_next, seen_upd;
   logic                  word_changed, accept, one_hot, multi_hot;
   logic [3:0]            lk_value;
   logic                  lk_legal, lk_blank;
   logic                  digit_wr, err_set, fv_set, tmo_clr;
   state_t                state, next_state;

   // Reset to the "all digits off" word so release does not look like a multi-hot scan.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1     <= {ANODE_IDLE, SEG_BLANK};
         sync2     <= {ANODE_IDLE, SEG_BLANK};
         sync_prev <= {ANODE_IDLE, SEG_BLANK};
      end else begin
         sync1     <= {anode, segment};
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   assign word_changed = (sync2 != sync_prev);
   assign accept       = !word_changed && (stab_cnt == STABLE_LAST);
   assign en           = ANODE_ACTIVE_LOW ? ~sync2[WORD_W-1:7] : sync2[WORD_W-1:7];
   assign one_hot      = $onehot(en);
   assign multi_hot    = (en != '0) && !one_hot;
   assign stalled      = (state == ST_STALL);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stab_cnt <= '0;
      end else if (word_changed) begin
         stab_cnt <= '0;
      end else if (stab_cnt != STABLE_MAX) begin
         stab_cnt <= stab_cnt + 1'b1;
      end
   end

   seg_pattern_lookup u_lookup (
      .segment  (sync2[6:0]),
      .value    (lk_value),
      .legal    (lk_legal),
      .is_blank (lk_blank)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      seen_upd   = seen | en;
      seen_next  = seen;
      digit_wr   = 1'b0;
      err_set    = 1'b0;
      fv_set     = 1'b0;
      tmo_clr    = 1'b0;
      if (accept && one_hot) begin
         tmo_clr = 1'b1;
         if (lk_legal) begin
            digit_wr   = 1'b1;
            next_state = ST_COLLECT;
            if (seen_upd == ALL_SEEN) begin
               fv_set    = 1'b1;
               seen_next = '0;
            end else begin
               seen_next = seen_upd;
            end
         end else begin
            err_set   = 1'b1;
            seen_next = '0;
         end
      end else if (accept && multi_hot) begin
         err_set   = 1'b1;
         seen_next = '0;
      end
      // Stall fires on the edge where the timeout count reaches TIMEOUT_CYCLES.
      if (state == ST_COLLECT && !tmo_clr && tmo_cnt >= TMO_LAST) begin
         next_state = ST_STALL;
         seen_next  = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (tmo_clr) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digits      <= '0;
         blank       <= '0;
         seen        <= '0;
         frame_valid <= 1'b0;
         error       <= 1'b0;
      end else begin
         seen        <= seen_next;
         frame_valid <= fv_set;
         error       <= err_set;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_wr && en[i]) begin
               digits[4*i +: 4] <= lk_value;
               blank[i]         <= lk_blank;
            end
         end
      end
   end

endmodule
